// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the pipelined add/sub/accumulate unit: op codes and
// the flag bundle carried alongside each result.
package adder_pipe_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  typedef struct packed {
    logic overflow;
    logic carry;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '{overflow: 1'b0, carry: 1'b0};

  // True when the op updates the running-sum register.
  function automatic logic writes_acc(input op_t op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/adder_pipe_core.sv
// Combinational WIDTH-bit add/sub/accumulate datapath with carry/borrow and
// signed overflow. Saturation on overflow is built only with ADDER_PIPE_SAT_EN.
module adder_pipe_core
  import adder_pipe_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic             sub;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH-1:0] rhs_eff;
  logic [WIDTH:0]   ext;
  logic             ovf;

  // ACC adds operand A onto the running sum; ADD/SUB use A and B directly.
  assign sub     = (op == OP_SUB);
  assign lhs     = (op == OP_ACC) ? acc : a;
  assign rhs     = (op == OP_ACC) ? a : b;
  assign rhs_eff = sub ? ~rhs : rhs;
  assign ext     = {1'b0, lhs} + {1'b0, rhs_eff} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    if (sub) begin
      ovf = (lhs[MSB] != rhs[MSB]) && (ext[MSB] != lhs[MSB]);
    end else begin
      ovf = (lhs[MSB] == rhs[MSB]) && (ext[MSB] != lhs[MSB]);
    end
  end

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path can infer a latch.
    result         = ext[WIDTH-1:0];
    flags.carry    = sub ? ~ext[WIDTH] : ext[WIDTH];
    flags.overflow = ovf;
`ifdef ADDER_PIPE_SAT_EN
    // On overflow the true result has the sign of lhs.
    if (ovf) begin
      result = lhs[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    if (op == OP_CLR) begin
      result = ACC_INIT;
      flags  = FLAGS_CLEAR;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Two-stage valid-tagged add/sub/accumulate pipeline with global stall enable.
// Optional macro ADDER_PIPE_SAT_EN enables signed saturation on overflow.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             In_valid,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Overflow,
  output logic             Carry,
  output logic             Out_valid
);

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;

  adder_pipe_core #(
    .WIDTH   (WIDTH),
    .ACC_INIT(ACC_INIT)
  ) u_core (
    .op    (s1_op),
    .a     (s1_a),
    .b     (s1_b),
    .acc   (acc),
    .result(core_result),
    .flags (core_flags)
  );

  // Stage 1: operand capture. Operands of a bubble are don't-care but harmless.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (En) begin
      s1_valid <= In_valid;
      s1_op    <= op_t'(Op);
      s1_a     <= A;
      s1_b     <= B;
    end
  end

  // Stage 2: result/flag registers hold through bubbles; only valid beats update them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Sum       <= '0;
      Overflow  <= 1'b0;
      Carry     <= 1'b0;
      Out_valid <= 1'b0;
    end else if (En) begin
      Out_valid <= s1_valid;
      if (s1_valid) begin
        Sum      <= core_result;
        Overflow <= core_flags.overflow;
        Carry    <= core_flags.carry;
      end
    end
  end

  // Acc is read and written only in stage 2, so consecutive ACC beats chain directly.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc <= ACC_INIT;
    end else if (En && s1_valid && writes_acc(s1_op)) begin
      acc <= core_result;
    end
  end

endmodule
